// File: rtl/aes_gcm_pkg.sv
// Shared types and helpers for the AES-GCM front-end sequencer.
// Beat payload struct, phase encoding and the GCM inc32 counter step.
package aes_gcm_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned KS_W  = 1408;

  typedef enum logic [1:0] {
    PH_BUBBLE = 2'b00,
    PH_AAD    = 2'b01,
    PH_PT     = 2'b10,
    PH_LEN    = 2'b11
  } phase_t;

  // One stage-1 pipeline beat
  typedef struct packed {
    logic             valid;
    phase_t           phase;
    logic             new_inst;
    logic [BLK_W-1:0] aad;
    logic [BLK_W-1:0] pt;
    logic [BLK_W-1:0] cb;
  } beat_t;

  // Increment the low 32-bit word modulo 2^32; the upper 96 bits pass through
  function automatic logic [BLK_W-1:0] fn_inc32(input logic [BLK_W-1:0] blk);
    logic [31:0] lo;
    lo = blk[31:0] + 32'd1;
    return {blk[BLK_W-1:32], lo};
  endfunction

endpackage

// File: rtl/aes_gcm_pipeline_sequencer_if.sv
// Block-input handshake between the data source and the AES-GCM sequencer.
interface aes_gcm_pipeline_sequencer_if;
  import aes_gcm_pkg::*;

  logic             i_blk_valid;
  logic [BLK_W-1:0] i_blk_data;
  logic             o_blk_ready;

  modport master (output i_blk_valid, output i_blk_data, input  o_blk_ready);
  modport slave  (input  i_blk_valid, input  i_blk_data, output o_blk_ready);

endinterface

// File: rtl/aes_gcm_pipeline_sequencer.sv
// Front-end sequencer feeding AAD, PT and length beats into the no-stall AES-GCM pipeline.
// Optional abort port/behaviour enabled by defining AES_GCM_SEQ_ABORT_EN.
module aes_gcm_pipeline_sequencer
  import aes_gcm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [KS_W-1:0]      i_key_schedule,
  input  logic [BLK_W-1:0]     i_j0,
  input  logic [CNT_W-1:0]     i_aad_blocks,
  input  logic [CNT_W-1:0]     i_pt_blocks,
  input  logic [BLK_W-1:0]     i_instance_size,
  aes_gcm_pipeline_sequencer_if.slave blk,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_valid,
  output logic [1:0]           o_phase,
  output logic                 o_new_instance,
  output logic [BLK_W-1:0]     o_plain_text,
  output logic [BLK_W-1:0]     o_aad,
  output logic [BLK_W-1:0]     o_h,
  output logic [BLK_W-1:0]     o_encrypted_j0,
  output logic [BLK_W-1:0]     o_encrypted_cb,
  output logic [KS_W-1:0]      o_key_schedule,
`ifdef AES_GCM_SEQ_ABORT_EN
  input  logic                 i_abort,
  output logic                 o_aborted,
`endif
  output logic [BLK_W-1:0]     o_instance_size
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AAD,
    S_PT,
    S_LEN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] aad_left_q, aad_left_d;
  logic [CNT_W-1:0] pt_left_q, pt_left_d;
  logic [BLK_W-1:0] cb_q, cb_d;
  logic             first_q, first_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  beat_t            beat_q, beat_d;
  logic             start_acc, blk_acc, abort_c;

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign blk_acc   = ready_q && blk.i_blk_valid;

`ifdef AES_GCM_SEQ_ABORT_EN
  assign abort_c = i_abort && (state_q != S_IDLE);
`else
  assign abort_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      aad_left_q      <= '0;
      pt_left_q       <= '0;
      cb_q            <= '0;
      first_q         <= 1'b0;
      ready_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      beat_q          <= '0;
      o_key_schedule  <= '0;
      o_encrypted_j0  <= '0;
      o_instance_size <= '0;
    end else begin
      state_q    <= state_d;
      aad_left_q <= aad_left_d;
      pt_left_q  <= pt_left_d;
      cb_q       <= cb_d;
      first_q    <= first_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      beat_q     <= beat_d;
      if (start_acc) begin
        o_key_schedule  <= i_key_schedule;
        o_encrypted_j0  <= i_j0;
        o_instance_size <= i_instance_size;
      end
    end
  end

`ifdef AES_GCM_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) o_aborted <= 1'b0;
    else     o_aborted <= abort_c;
  end
`endif

  // Next-state logic; an empty phase is skipped straight through
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_aad_blocks != '0)     state_d = S_AAD;
          else if (i_pt_blocks != '0) state_d = S_PT;
          else                        state_d = S_LEN;
        end
      end
      S_AAD: begin
        if (blk_acc && (aad_left_q == CNT_W'(1)))
          state_d = (pt_left_q != '0) ? S_PT : S_LEN;
      end
      S_PT: begin
        if (blk_acc && (pt_left_q == CNT_W'(1))) state_d = S_LEN;
      end
      S_LEN:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_c) state_d = S_IDLE;
  end

  // Next values for the registered beat, counters and status outputs
  always_comb begin
    aad_left_d = aad_left_q;
    pt_left_d  = pt_left_q;
    cb_d       = cb_q;
    first_d    = first_q;
    beat_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          aad_left_d = i_aad_blocks;
          pt_left_d  = i_pt_blocks;
          cb_d       = fn_inc32(i_j0);
          first_d    = 1'b1;
        end
      end
      S_AAD: begin
        if (blk_acc) begin
          beat_d.valid    = 1'b1;
          beat_d.phase    = PH_AAD;
          beat_d.new_inst = first_q;
          beat_d.aad      = blk.i_blk_data;
          first_d         = 1'b0;
          aad_left_d      = aad_left_q - CNT_W'(1);
        end
      end
      S_PT: begin
        if (blk_acc) begin
          beat_d.valid    = 1'b1;
          beat_d.phase    = PH_PT;
          beat_d.new_inst = first_q;
          beat_d.pt       = blk.i_blk_data;
          beat_d.cb       = cb_q;
          first_d         = 1'b0;
          cb_d            = fn_inc32(cb_q);
          pt_left_d       = pt_left_q - CNT_W'(1);
        end
      end
      S_LEN: begin
        beat_d.valid    = 1'b1;
        beat_d.phase    = PH_LEN;
        beat_d.new_inst = first_q;
        first_d         = 1'b0;
      end
      default: ;
    endcase
    if (abort_c) begin
      beat_d  = '0;
      first_d = 1'b0;
    end
    ready_d = (state_d == S_AAD) || (state_d == S_PT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_DONE) && !abort_c;
  end

  assign blk.o_blk_ready = ready_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_valid         = beat_q.valid;
  assign o_phase         = beat_q.phase;
  assign o_new_instance  = beat_q.new_inst;
  assign o_aad           = beat_q.aad;
  assign o_plain_text    = beat_q.pt;
  assign o_encrypted_cb  = beat_q.cb;
  assign o_h             = '0;

endmodule

// File: tb/tb_aes_gcm_pipeline_sequencer.sv
// Directed table-driven bench for aes_gcm_pipeline_sequencer, plus reset/abort sequences.
// Abort sequence is compiled only when AES_GCM_SEQ_ABORT_EN is defined.
module tb_aes_gcm_pipeline_sequencer;
  import aes_gcm_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam logic [95:0] JHI  = 96'hA5A5_0123_4567_89AB_CDEF_F00D;
  localparam logic [95:0] DHI  = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [31:0] JUNK = 32'hDEAD_0000;

  logic              clk, rst, i_start;
  logic [KS_W-1:0]   i_key_schedule;
  logic [BLK_W-1:0]  i_j0, i_instance_size;
  logic [CNT_W-1:0]  i_aad_blocks, i_pt_blocks;
  logic              o_busy, o_done, o_valid, o_new_instance;
  logic [1:0]        o_phase;
  logic [BLK_W-1:0]  o_plain_text, o_aad, o_h, o_encrypted_j0, o_encrypted_cb, o_instance_size;
  logic [KS_W-1:0]   o_key_schedule;
`ifdef AES_GCM_SEQ_ABORT_EN
  logic              i_abort, o_aborted;
`endif

  aes_gcm_pipeline_sequencer_if bif ();

  aes_gcm_pipeline_sequencer #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_key_schedule  (i_key_schedule),
    .i_j0            (i_j0),
    .i_aad_blocks    (i_aad_blocks),
    .i_pt_blocks     (i_pt_blocks),
    .i_instance_size (i_instance_size),
    .blk             (bif.slave),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_valid         (o_valid),
    .o_phase         (o_phase),
    .o_new_instance  (o_new_instance),
    .o_plain_text    (o_plain_text),
    .o_aad           (o_aad),
    .o_h             (o_h),
    .o_encrypted_j0  (o_encrypted_j0),
    .o_encrypted_cb  (o_encrypted_cb),
    .o_key_schedule  (o_key_schedule),
`ifdef AES_GCM_SEQ_ABORT_EN
    .i_abort         (i_abort),
    .o_aborted       (o_aborted),
`endif
    .o_instance_size (o_instance_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst, start;
    int unsigned aad, pt;
    logic [31:0] j0_lo;
    bit          v;
    logic [31:0] d_lo;
    bit          e_ready, e_busy, e_done, e_valid;
    logic [1:0]  e_phase;
    bit          e_new;
    logic [31:0] e_d, e_cb;
  } vec_t;

  vec_t             vecs[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [BLK_W-1:0] cur_j0, cur_size;
  logic [KS_W-1:0]  cur_ks;

  function automatic vec_t mk(bit r, bit s, int unsigned a, int unsigned p, logic [31:0] j,
                              bit v, logic [31:0] d, bit er, bit eb, bit ed, bit ev,
                              logic [1:0] eph, bit en, logic [31:0] edat, logic [31:0] ecb);
    vec_t x;
    x.rst = r; x.start = s; x.aad = a; x.pt = p; x.j0_lo = j; x.v = v; x.d_lo = d;
    x.e_ready = er; x.e_busy = eb; x.e_done = ed; x.e_valid = ev;
    x.e_phase = eph; x.e_new = en; x.e_d = edat; x.e_cb = ecb;
    return x;
  endfunction

  function automatic logic [KS_W-1:0] ks_of(logic [BLK_W-1:0] j);
    return {11{j ^ 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0}};
  endfunction

  function automatic logic [BLK_W-1:0] size_of(int unsigned a, int unsigned p);
    logic [63:0] la, lc;
    la = 64'(a) << 7;
    lc = 64'(p) << 7;
    return {la, lc};
  endfunction

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ks(input string nm, input logic [KS_W-1:0] act, input logic [KS_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: key schedule differs, low words got %h expected %h", nm,
               act[BLK_W-1:0], exp[BLK_W-1:0]);
    end
  endtask

  task automatic set_in(bit r, bit s, int unsigned a, int unsigned p, logic [31:0] j,
                        bit v, logic [31:0] d);
    rst             = r;
    i_start         = s;
    i_aad_blocks    = CNT_W'(a);
    i_pt_blocks     = CNT_W'(p);
    i_j0            = {JHI, j};
    i_key_schedule  = ks_of({JHI, j});
    i_instance_size = size_of(a, p);
    bif.i_blk_valid = v;
    bif.i_blk_data  = {DHI, d};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    bit   got;
`ifdef AES_GCM_SEQ_ABORT_EN
    i_abort = 1'b0;
`endif
    set_in(1, 0, 0, 0, JUNK, 0, 0);

    // reset
    vecs.push_back(mk(1,0,0,0,JUNK,0,0,            0,0,0,0,2'd0,0,0,0));
    vecs.push_back(mk(1,0,0,0,JUNK,1,32'h5,        0,0,0,0,2'd0,0,0,0));
    // basic: aad=1 pt=2, J0 low word 1; valid high in IDLE is ignored
    vecs.push_back(mk(0,1,1,2,32'h1,1,32'h11,      1,1,0,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h11,       1,1,0,1,2'd1,1,32'h11,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h21,       1,1,0,1,2'd2,0,32'h21,32'h2));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h22,       0,1,0,1,2'd2,0,32'h22,32'h3));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h99,       0,1,0,1,2'd3,0,0,0));
    vecs.push_back(mk(0,1,7,7,JUNK,1,32'h99,       0,0,1,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,0,0,0,2'd0,0,0,0));
    // zero lengths
    vecs.push_back(mk(0,1,0,0,32'h100,1,32'h55,    0,1,0,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h55,       0,1,0,1,2'd3,1,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h55,       0,0,1,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,0,0,0,2'd0,0,0,0));
    // inc32 wrap
    vecs.push_back(mk(0,1,0,3,32'hFFFF_FFFE,0,0,   1,1,0,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h31,       1,1,0,1,2'd2,1,32'h31,32'hFFFF_FFFF));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h32,       1,1,0,1,2'd2,0,32'h32,32'h0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h33,       0,1,0,1,2'd2,0,32'h33,32'h1));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,1,0,1,2'd3,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,0,1,0,2'd0,0,0,0));
    // earliest restart, then back-pressure gaps with aad=2
    vecs.push_back(mk(0,1,2,0,32'h5000,0,0,        1,1,0,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h41,       1,1,0,1,2'd1,1,32'h41,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,32'h77,       1,1,0,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,32'h77,       1,1,0,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,1,32'h42,       0,1,0,1,2'd1,0,32'h42,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,1,0,1,2'd3,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,0,1,0,2'd0,0,0,0));
    vecs.push_back(mk(0,0,7,7,JUNK,0,0,            0,0,0,0,2'd0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      set_in(v.rst, v.start, v.aad, v.pt, v.j0_lo, v.v, v.d_lo);
      if (v.start) begin
        cur_j0   = {JHI, v.j0_lo};
        cur_ks   = ks_of({JHI, v.j0_lo});
        cur_size = size_of(v.aad, v.pt);
      end
      tick();
      chk($sformatf("v%0d_ready", i), BLK_W'(bif.o_blk_ready), BLK_W'(v.e_ready));
      chk($sformatf("v%0d_busy",  i), BLK_W'(o_busy),          BLK_W'(v.e_busy));
      chk($sformatf("v%0d_done",  i), BLK_W'(o_done),          BLK_W'(v.e_done));
      chk($sformatf("v%0d_valid", i), BLK_W'(o_valid),         BLK_W'(v.e_valid));
      chk($sformatf("v%0d_phase", i), BLK_W'(o_phase),         BLK_W'(v.e_phase));
      chk($sformatf("v%0d_new",   i), BLK_W'(o_new_instance),  BLK_W'(v.e_new));
      chk($sformatf("v%0d_aad",   i), o_aad,
          (v.e_phase == 2'd1) ? {DHI, v.e_d} : '0);
      chk($sformatf("v%0d_pt",    i), o_plain_text,
          (v.e_phase == 2'd2) ? {DHI, v.e_d} : '0);
      chk($sformatf("v%0d_cb",    i), o_encrypted_cb,
          (v.e_phase == 2'd2) ? {JHI, v.e_cb} : '0);
      chk($sformatf("v%0d_h",     i), o_h, '0);
      if (v.rst) begin
        chk($sformatf("v%0d_rst_j0",   i), o_encrypted_j0,  '0);
        chk($sformatf("v%0d_rst_size", i), o_instance_size, '0);
        chk_ks($sformatf("v%0d_rst_ks", i), o_key_schedule, '0);
      end else if (v.e_busy) begin
        chk($sformatf("v%0d_j0",   i), o_encrypted_j0,  cur_j0);
        chk($sformatf("v%0d_size", i), o_instance_size, cur_size);
        chk_ks($sformatf("v%0d_ks", i), o_key_schedule, cur_ks);
      end
    end

    // reset in the middle of a 4-block PT phase
    set_in(0, 1, 0, 4, 32'h10, 0, 0);
    tick();
    set_in(0, 0, 7, 7, JUNK, 1, 32'h61);
    tick();
    chk("mid_pt_beat", o_plain_text, {DHI, 32'h61});
    chk("mid_pt_cb", o_encrypted_cb, {JHI, 32'h11});
    set_in(0, 1, 3, 3, 32'h7777, 0, 0);
    tick();
    chk("busy_start_j0", o_encrypted_j0, {JHI, 32'h10});
    chk("busy_start_bubble", BLK_W'(o_valid), '0);
    set_in(1, 0, 7, 7, JUNK, 1, 32'h62);
    tick();
    chk("rst_busy",  BLK_W'(o_busy), '0);
    chk("rst_ready", BLK_W'(bif.o_blk_ready), '0);
    chk("rst_valid", BLK_W'(o_valid), '0);
    chk("rst_phase", BLK_W'(o_phase), '0);
    chk("rst_pt",    o_plain_text, '0);
    chk("rst_cb",    o_encrypted_cb, '0);
    chk("rst_j0",    o_encrypted_j0, '0);
    chk("rst_size",  o_instance_size, '0);
    chk_ks("rst_ks", o_key_schedule, '0);
    set_in(0, 1, 1, 0, 32'h20, 1, 32'h71);
    tick();
    chk("restart_ready", BLK_W'(bif.o_blk_ready), 1);
    chk("restart_done_low", BLK_W'(o_done), '0);
    set_in(0, 0, 7, 7, JUNK, 1, 32'h71);
    tick();
    chk("restart_aad", o_aad, {DHI, 32'h71});
    chk("restart_new", BLK_W'(o_new_instance), 1);
    bif.i_blk_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (o_done) got = 1'b1;
    end
    chk("restart_done", BLK_W'(got), 1);

`ifdef AES_GCM_SEQ_ABORT_EN
    // abort during AAD
    tick();
    set_in(0, 1, 2, 1, 32'h30, 0, 0);
    tick();
    set_in(0, 0, 7, 7, JUNK, 1, 32'h81);
    tick();
    chk("ab_aad_beat", o_aad, {DHI, 32'h81});
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("ab_aborted", BLK_W'(o_aborted), 1);
    chk("ab_done",    BLK_W'(o_done), '0);
    chk("ab_valid",   BLK_W'(o_valid), '0);
    chk("ab_phase",   BLK_W'(o_phase), '0);
    chk("ab_busy",    BLK_W'(o_busy), '0);
    chk("ab_ready",   BLK_W'(bif.o_blk_ready), '0);
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_valid || o_done || o_aborted) got = 1'b1;
    end
    chk("ab_quiet_after", BLK_W'(got), '0);
    bif.i_blk_valid = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("ab_idle_no_effect", BLK_W'(o_aborted), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_gcm_pipeline_sequencer.md
Name: aes_gcm_pipeline_sequencer

Overview:
- Front-end controller for the AES-GCM pipeline. It feeds the stage-1 input bus of the pipeline.
- Accepts one GCM instance at a time: key schedule, pre-counter block J0, AAD/PT block counts and the len(A)||len(C) block.
- Streams AAD blocks, then PT blocks, then one length beat into the pipeline. Each beat is tagged with phase, new-instance flag and the inc32 counter block.
- The pipeline has no stall, so this block is the single point of flow control.

Parameters:
- CNT_W, 16, width of the AAD and PT block counters (max 2^CNT_W-1 blocks each).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  start new instance; sampled only in IDLE.
- i_key_schedule  in  [0:1407]  expanded key; latched on accepted start.
- i_j0  in  [0:127]  pre-counter block J0; latched on start.
- i_aad_blocks  in  CNT_W  number of AAD blocks.
- i_pt_blocks  in  CNT_W  number of PT blocks.
- i_instance_size  in  [0:127]  len(A)||len(C) block.
- i_blk_valid  in  1  input data block valid.
- i_blk_data  in  [0:127]  AAD or PT block.
- o_blk_ready  out  1  block accepted when i_blk_valid && o_blk_ready.
- o_busy  out  1  instance in progress.
- o_done  out  1  one-cycle pulse after the length beat is issued.
- o_valid  out  1  pipeline beat valid.
- o_phase  out  [0:1]  00 bubble, 01 AAD, 10 PT, 11 LEN.
- o_new_instance  out  1  first beat of an instance.
- o_plain_text  out  [0:127]  PT block, else zero.
- o_aad  out  [0:127]  AAD block, else zero.
- o_h  out  [0:127]  always 128'h0; the pipeline encrypts it to H.
- o_encrypted_j0  out  [0:127]  latched J0.
- o_encrypted_cb  out  [0:127]  counter block for PT beats.
- o_key_schedule  out  [0:1407]  latched key schedule.
- o_instance_size  out  [0:127]  latched length block.

Behaviour:
- States: IDLE, AAD, PT, LEN, DONE. One clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All outputs 0, including o_valid, o_phase=00, o_busy, o_done and o_blk_ready.
  - Latched key, J0, size and counters all cleared to 0.
- IDLE:
  - o_busy=0, o_blk_ready=0.
  - On i_start: latch all instance inputs and set cb=inc32(J0).
  - Next state is AAD if aad>0, else PT if pt>0, else LEN.
  - Raise a first-beat flag.
- AAD / PT:
  - o_blk_ready=1.
  - Each accepted block produces one beat on the next cycle: o_valid=1, phase=01 or 10, the block on o_aad or o_plain_text (the other field zero), and o_new_instance=first-beat flag. The flag clears after that beat.
  - PT beats carry the current cb; cb then advances by inc32.
  - No accepted block means o_valid=0 and phase=00 for that cycle (bubble).
  - Transition on the last block of each phase: AAD to PT (or LEN if pt=0), PT to LEN.
- LEN:
  - Unconditionally issues one beat next cycle: phase=11, o_aad=o_plain_text=0, new_instance=flag.
  - Next state DONE.
- DONE:
  - o_done=1 for one cycle, o_busy=0 on the following cycle, return to IDLE.
  - i_start is not accepted in DONE; the earliest restart is the cycle after DONE.
- o_busy is 1 in AAD, PT, LEN and DONE.
- Latency: block accepted in cycle N appears on outputs in cycle N+1. All outputs are registered.
- inc32: the low 32 bits increment mod 2^32; bits [0:95] are unchanged. Wrap from 32'hFFFFFFFF to 0 is legal and is not flagged.
- o_key_schedule, o_encrypted_j0, o_instance_size and o_h stay stable for the whole instance, including bubbles.
- i_start while busy is ignored.
- i_blk_valid in IDLE, LEN or DONE is ignored; no ready is given.
- rst mid-instance returns to IDLE at the next edge with all outputs cleared. No done is issued.

Optional Feature:
- Macro AES_GCM_SEQ_ABORT_EN.
- When defined:
  - Adds input i_abort (1 bit).
  - i_abort in any non-IDLE state forces IDLE at the next edge.
  - Drives one bubble beat (o_valid=0, phase=00).
  - Pulses o_done=0 and adds output o_aborted=1 for one cycle.
  - i_abort in IDLE has no effect.
- When undefined: neither port exists and behaviour is as above.

Decomposition:
- Shared package aes_gcm_pkg holds:
  - phase_t enum (PH_BUBBLE=2'b00, PH_AAD=2'b01, PH_PT=2'b10, PH_LEN=2'b11).
  - Constants BLK_W=128 and KS_W=1408.
  - Function fn_inc32.
- The FSM state enum stays local to the module.
- No sub-module; the counters and inc32 are small enough to sit inline.

Test Plan:
- Basic instance: J0=...0000_0001, aad=1, pt=2, valid held high. Required response:
  - Beats are AAD (new=1), PT cb=...0002, PT cb=...0003, LEN.
  - o_done pulses one cycle after the LEN beat.
- Zero lengths: aad=0, pt=0. Single LEN beat with new=1, then done; o_blk_ready never asserts.
- Wrap: J0 low word FFFF_FFFE, pt=3. Required response:
  - cb low words are FFFF_FFFF, 0000_0000, 0000_0001.
  - Upper 96 bits are unchanged.
- Back-pressure gaps: i_blk_valid toggles 1,0,0,1 with aad=2. Required response:
  - Beats appear one cycle after each acceptance.
  - Gap cycles have o_valid=0 and phase=00.
  - Only the first beat has new=1.
- Reset mid-PT: assert rst after the 1st of 4 PT blocks. Required response:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new start then works normally.
- Abort (macro on): i_abort during AAD. o_aborted pulses, o_done stays 0, no LEN beat is issued, and the block returns to IDLE.
